// File: rtl/k_alu8_pkg.sv
// Shared types and command-word field positions for the k_alu8 execute-stage ALU.
// Optional flag outputs are enabled by defining K_ALU8_FLAGS_EN.
package k_alu8_pkg;

   typedef enum logic [3:0] {
      FN_ADD   = 4'b0000,
      FN_SUB   = 4'b0001,
      FN_AND   = 4'b0010,
      FN_OR    = 4'b0011,
      FN_XOR   = 4'b0100,
      FN_NOR   = 4'b0101,
      FN_SLL   = 4'b0110,
      FN_SRL   = 4'b0111,
      FN_SRA   = 4'b1000,
      FN_INC   = 4'b1001,
      FN_DEC   = 4'b1010,
      FN_SLT   = 4'b1011,
      FN_SGT   = 4'b1100,
      FN_HAM   = 4'b1101,
      FN_NOT   = 4'b1110,
      FN_PASSB = 4'b1111
   } func_e;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_mode_e;

   localparam int FUNC_MSB = 31;
   localparam int FUNC_LSB = 28;
   localparam int A_MSB    = 15;
   localparam int A_LSB    = 8;
   localparam int B_MSB    = 7;
   localparam int B_LSB    = 0;

   function automatic logic [7:0] popcount8(input logic [7:0] v);
      logic [7:0] cnt;
      cnt = 8'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {7'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/k_alu8_shifter.sv
// Combinational 8-bit shifter for k_alu8; the full 8-bit shift amount is honoured,
// so any amount of 8 or more saturates to zero (or sign fill for SRA).
module k_alu8_shifter
   import k_alu8_pkg::*;
(
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  shift_mode_e mode,
   output logic [7:0]  y
);

   logic saturate;

   assign saturate = |b[7:3];

   always_comb begin
      y = a;
      if (saturate) begin
         case (mode)
            SH_SRA:  y = {8{a[7]}};
            default: y = 8'h00;
         endcase
      end else begin
         case (mode)
            SH_SLL:  y = a << b[2:0];
            SH_SRL:  y = a >> b[2:0];
            SH_SRA:  y = $unsigned($signed(a) >>> b[2:0]);
            default: y = a;
         endcase
      end
   end

endmodule

// File: rtl/k_alu8.sv
// Registered 8-bit ALU decoding a 32-bit command word; result appears one edge later.
// Define K_ALU8_FLAGS_EN to add registered Z/C/V flag outputs.
module k_alu8
   import k_alu8_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] command,
`ifdef K_ALU8_FLAGS_EN
   output logic        Z,
   output logic        C,
   output logic        V,
`endif
   output logic [7:0]  RES
);

   func_e       func;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [11:0] rsvd_unused;
   shift_mode_e shift_mode;
   logic [7:0]  shift_y;
   logic [8:0]  add_w;
   logic [8:0]  sub_w;
   logic [7:0]  res_d;
   logic [7:0]  res_q;

   assign func        = func_e'(command[FUNC_MSB:FUNC_LSB]);
   assign op_a        = command[A_MSB:A_LSB];
   assign op_b        = command[B_MSB:B_LSB];
   assign rsvd_unused = command[27:16];

   assign shift_mode = (func == FN_SLL) ? SH_SLL :
                       (func == FN_SRL) ? SH_SRL : SH_SRA;

   k_alu8_shifter u_shifter (
      .a    (op_a),
      .b    (op_b),
      .mode (shift_mode),
      .y    (shift_y)
   );

   // Ninth bit of each sum is the carry (ADD) or borrow (SUB).
   assign add_w = {1'b0, op_a} + {1'b0, op_b};
   assign sub_w = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      res_d = 8'h00;
      case (func)
         FN_ADD:   res_d = add_w[7:0];
         FN_SUB:   res_d = sub_w[7:0];
         FN_AND:   res_d = op_a & op_b;
         FN_OR:    res_d = op_a | op_b;
         FN_XOR:   res_d = op_a ^ op_b;
         FN_NOR:   res_d = ~(op_a | op_b);
         FN_SLL,
         FN_SRL,
         FN_SRA:   res_d = shift_y;
         FN_INC:   res_d = op_a + 8'd1;
         FN_DEC:   res_d = op_a - 8'd1;
         FN_SLT:   res_d = {7'd0, $signed(op_a) < $signed(op_b)};
         FN_SGT:   res_d = {7'd0, $signed(op_a) > $signed(op_b)};
         FN_HAM:   res_d = popcount8(op_a);
         FN_NOT:   res_d = ~op_a;
         FN_PASSB: res_d = op_b;
         default:  res_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= 8'h00;
      end else begin
         res_q <= res_d;
      end
   end

   assign RES = res_q;

`ifdef K_ALU8_FLAGS_EN
   logic z_d, c_d, v_d;
   logic z_q, c_q, v_q;

   always_comb begin
      z_d = (res_d == 8'h00);
      c_d = 1'b0;
      v_d = 1'b0;
      case (func)
         FN_ADD: begin
            c_d = add_w[8];
            v_d = (op_a[7] == op_b[7]) && (add_w[7] != op_a[7]);
         end
         FN_SUB: begin
            c_d = sub_w[8];
            v_d = (op_a[7] != op_b[7]) && (sub_w[7] != op_a[7]);
         end
         FN_INC: begin
            c_d = (op_a == 8'hFF);
            v_d = (op_a == 8'h7F);
         end
         FN_DEC: begin
            c_d = (op_a == 8'h00);
            v_d = (op_a == 8'h80);
         end
         default: begin
            c_d = 1'b0;
            v_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         z_q <= z_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign Z = z_q;
   assign C = c_q;
   assign V = v_q;
`endif

endmodule

// File: tb/tb_k_alu8.sv
// Directed-vector bench for k_alu8; flag checks are included when K_ALU8_FLAGS_EN is defined.
module tb_k_alu8;

   logic        clk;
   logic        rst_n;
   logic [31:0] command;
   logic [7:0]  RES;
`ifdef K_ALU8_FLAGS_EN
   logic        Z, C, V;
`endif

   int checkCount = 0;
   int errorCount = 0;

   k_alu8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .command (command),
`ifdef K_ALU8_FLAGS_EN
      .Z       (Z),
      .C       (C),
      .V       (V),
`endif
      .RES     (RES)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %02h, expected %02h", tag, got, exp);
      end
   endtask

   // Drive a command on the falling edge, then sample just after the next rising edge.
   task automatic applyStimulus(input logic [3:0] func, input logic [7:0] a,
                                input logic [7:0] b, input logic [11:0] rsvd);
      @(negedge clk);
      command = {func, rsvd, a, b};
      @(posedge clk);
      #1;
   endtask

   logic [7:0] sweepExp [16];

   initial begin
      sweepExp = '{8'h5F, 8'h5B, 8'h00, 8'h5F, 8'h5F, 8'hA0, 8'h74, 8'h17,
                   8'h17, 8'h5E, 8'h5C, 8'h00, 8'h01, 8'h05, 8'hA2, 8'h02};

      rst_n   = 1'b0;
      command = {4'h0, 12'h000, 8'h5D, 8'h02};
      #3;
      checkOutput("reset_res", RES, 8'h00);
`ifdef K_ALU8_FLAGS_EN
      checkOutput("reset_flags", {5'd0, Z, C, V}, 8'h00);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(i[3:0], 8'h5D, 8'h02, 12'h000);
         checkOutput($sformatf("sweep_f%0d", i), RES, sweepExp[i]);
         if (i == 7) begin
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("async_reset", RES, 8'h00);
            @(posedge clk);
            #1;
            checkOutput("reset_held", RES, 8'h00);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("reset_release", RES, 8'h17);
         end
      end

      applyStimulus(4'h0, 8'hFF, 8'h01, 12'h000);
      checkOutput("wrap_add", RES, 8'h00);
`ifdef K_ALU8_FLAGS_EN
      checkOutput("wrap_add_zc", {6'd0, Z, C}, 8'h03);
`endif
      applyStimulus(4'h9, 8'hFF, 8'h00, 12'h000);
      checkOutput("wrap_inc", RES, 8'h00);
      applyStimulus(4'hA, 8'h00, 8'h00, 12'h000);
      checkOutput("wrap_dec", RES, 8'hFF);
      applyStimulus(4'h1, 8'h00, 8'h01, 12'h000);
      checkOutput("wrap_sub", RES, 8'hFF);
`ifdef K_ALU8_FLAGS_EN
      checkOutput("wrap_sub_c", {7'd0, C}, 8'h01);
      applyStimulus(4'h0, 8'h7F, 8'h01, 12'h000);
      checkOutput("ovf_add_v", {7'd0, V}, 8'h01);
`endif

      applyStimulus(4'h6, 8'h96, 8'h03, 12'h000);
      checkOutput("sll_3", RES, 8'hB0);
      applyStimulus(4'h7, 8'h96, 8'h03, 12'h000);
      checkOutput("srl_3", RES, 8'h12);
      applyStimulus(4'h8, 8'h96, 8'h03, 12'h000);
      checkOutput("sra_3", RES, 8'hF2);
      applyStimulus(4'h6, 8'h96, 8'h09, 12'h000);
      checkOutput("sll_9", RES, 8'h00);
      applyStimulus(4'h7, 8'h96, 8'h09, 12'h000);
      checkOutput("srl_9", RES, 8'h00);
      applyStimulus(4'h8, 8'h96, 8'h09, 12'h000);
      checkOutput("sra_9", RES, 8'hFF);
      applyStimulus(4'h8, 8'h56, 8'h10, 12'h000);
      checkOutput("sra_16_pos", RES, 8'h00);
      applyStimulus(4'h6, 8'h96, 8'h00, 12'h000);
      checkOutput("sll_0", RES, 8'h96);

      applyStimulus(4'hB, 8'h80, 8'h01, 12'h000);
      checkOutput("slt_neg", RES, 8'h01);
      applyStimulus(4'hC, 8'h80, 8'h01, 12'h000);
      checkOutput("sgt_neg", RES, 8'h00);
      applyStimulus(4'hB, 8'h40, 8'h40, 12'h000);
      checkOutput("slt_eq", RES, 8'h00);
      applyStimulus(4'hC, 8'h40, 8'h40, 12'h000);
      checkOutput("sgt_eq", RES, 8'h00);

      applyStimulus(4'h4, 8'h3C, 8'hA5, 12'h000);
      checkOutput("rsvd_base", RES, 8'h99);
      applyStimulus(4'h4, 8'h3C, 8'hA5, 12'hFFF);
      checkOutput("rsvd_ones", RES, 8'h99);
      applyStimulus(4'hD, 8'hFF, 8'h00, 12'hA5A);
      checkOutput("rsvd_ham", RES, 8'h08);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
